// File: rtl/soc_periph_router.sv
// Round-robin router from NrMasters requesters onto the decoded SoC peripheral target, one transaction in flight.
// Latency: grant same cycle; response 3 cycles after grant with a zero-wait target, 1 cycle on decode miss.
// Backpressure: requests are held ungranted until IDLE; a stalled target is aborted after TimeoutCycles.
module soc_periph_router #(
  parameter int unsigned NrMasters     = 2,
  parameter int unsigned NrSlaves      = 10,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NrMasters-1:0]             m_req_i,
  input  logic [NrMasters*AddrWidth-1:0]   m_addr_i,
  input  logic [NrMasters-1:0]             m_we_i,
  input  logic [NrMasters*DataWidth-1:0]   m_wdata_i,
  input  logic [NrMasters*DataWidth/8-1:0] m_be_i,
  output logic [NrMasters-1:0]             m_gnt_o,
  output logic [NrMasters-1:0]             m_rvalid_o,
  output logic [DataWidth-1:0]             m_rdata_o,
  output logic                             m_err_o,
  output logic [NrSlaves-1:0]              s_req_o,
  output logic [AddrWidth-1:0]             s_addr_o,
  output logic                             s_we_o,
  output logic [DataWidth-1:0]             s_wdata_o,
  output logic [DataWidth/8-1:0]           s_be_o,
  input  logic [NrSlaves-1:0]              s_gnt_i,
  input  logic [NrSlaves-1:0]              s_rvalid_i,
  input  logic [NrSlaves*DataWidth-1:0]    s_rdata_i,
  input  logic [NrSlaves-1:0]              s_err_i,
  output logic                             timeout_o
);
  localparam int unsigned BeWidth   = DataWidth / 8;
  localparam int unsigned IdW       = (NrMasters > 1) ? $clog2(NrMasters) : 1;
  localparam int unsigned IdxW      = (NrSlaves > 1) ? $clog2(NrSlaves) : 1;
  localparam int unsigned CntW      = $clog2(TimeoutCycles + 1);
  localparam int unsigned NrRegions = 10;

  localparam logic [63:0] RegBase [NrRegions] = '{
    64'h0000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000, 64'h1000_0000,
    64'h2000_0000, 64'h3000_0000, 64'h4000_0000, 64'h5000_0000, 64'h8000_0000};
  localparam logic [63:0] RegLen [NrRegions] = '{
    64'h0000_1000, 64'h0001_0000, 64'h000C_0000, 64'h03FF_FFFF, 64'h0000_1000,
    64'h0080_0000, 64'h0001_0000, 64'h0000_1000, 64'h0200_0000, 64'h4000_0000};
  localparam int unsigned RegIdx [NrRegions] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 0};

  typedef enum logic [2:0] {IDLE, SLV_REQ, WAIT_RSP, RSP, ERR_RSP} state_t;

  typedef struct packed {
    logic [IdW-1:0]       id;
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
    logic [IdxW-1:0]      idx;
  } req_t;

  typedef struct packed {
    logic            hit;
    logic [IdxW-1:0] idx;
  } dec_t;

  // Offset compare (addr - base < len) avoids overflow of base+len at the top of the space.
  function automatic dec_t decode(input logic [AddrWidth-1:0] addr);
    dec_t d;
    logic [AddrWidth-1:0] base;
    logic [AddrWidth-1:0] len;
    d = '0;
    for (int i = 0; i < NrRegions; i++) begin
      base = AddrWidth'(RegBase[i]);
      len  = AddrWidth'(RegLen[i]);
      if (addr >= base && (addr - base) < len) begin
        d.hit = 1'b1;
        d.idx = IdxW'(RegIdx[i]);
      end
    end
    return d;
  endfunction

  state_t               state_q, state_d;
  req_t                 req_q, req_d;
  logic [IdW-1:0]       rr_q, rr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 any_req;
  logic [IdW-1:0]       sel;
  logic [IdW-1:0]       nxt_id;
  logic                 tmo;
  dec_t                 dec;
  int                   j;

  // Scan downward so the lowest offset from the rr pointer wins.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    j       = 0;
    for (int k = NrMasters - 1; k >= 0; k--) begin
      j = (int'(rr_q) + k) % int'(NrMasters);
      if (m_req_i[j]) begin
        any_req = 1'b1;
        sel     = IdW'(j);
      end
    end
    any_req = any_req & rst_ni;
  end

  assign dec    = decode(m_addr_i[sel*AddrWidth +: AddrWidth]);
  assign nxt_id = (req_q.id == IdW'(NrMasters - 1)) ? '0 : req_q.id + IdW'(1);
  assign tmo    = (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = 1'b0;
    s_req_o    = '0;
    timeout_o  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          m_gnt_o[sel] = 1'b1;
          req_d.id     = sel;
          req_d.addr   = m_addr_i[sel*AddrWidth +: AddrWidth];
          req_d.we     = m_we_i[sel];
          req_d.wdata  = m_wdata_i[sel*DataWidth +: DataWidth];
          req_d.be     = m_be_i[sel*BeWidth +: BeWidth];
          req_d.idx    = dec.hit ? dec.idx : '0;
          state_d      = dec.hit ? SLV_REQ : ERR_RSP;
        end
      end
      SLV_REQ: begin
        cnt_d = cnt_q + CntW'(1);
        if (tmo) begin
          timeout_o = 1'b1;
          state_d   = ERR_RSP;
        end else begin
          s_req_o[req_q.idx] = 1'b1;
          if (s_gnt_i[req_q.idx]) state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + CntW'(1);
        // A response arriving on the limit cycle still completes normally.
        if (s_rvalid_i[req_q.idx]) begin
          rdata_d = s_rdata_i[req_q.idx*DataWidth +: DataWidth];
          err_d   = s_err_i[req_q.idx];
          state_d = RSP;
        end else if (tmo) begin
          timeout_o = 1'b1;
          state_d   = ERR_RSP;
        end
      end
      RSP: begin
        m_rvalid_o[req_q.id] = 1'b1;
        m_rdata_o            = rdata_q;
        m_err_o              = err_q;
        rr_d                 = nxt_id;
        state_d              = IDLE;
      end
      ERR_RSP: begin
        m_rvalid_o[req_q.id] = 1'b1;
        m_err_o              = 1'b1;
        rr_d                 = nxt_id;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign s_addr_o  = req_q.addr;
  assign s_we_o    = req_q.we;
  assign s_wdata_o = req_q.wdata;
  assign s_be_o    = req_q.be;

endmodule

// File: tb/tb_soc_periph_router.sv
// Directed bench for soc_periph_router: stimulus pushes expected grants, target requests and responses into queues;
// independent monitor and target-model processes pop and compare as the DUT presents them.
module tb_soc_periph_router;
  localparam int NM = 2, NS = 10, AW = 64, DW = 64, BW = 8, TMO = 16;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NM-1:0]       m_req_i;
  logic [NM*AW-1:0]    m_addr_i;
  logic [NM-1:0]       m_we_i;
  logic [NM*DW-1:0]    m_wdata_i;
  logic [NM*BW-1:0]    m_be_i;
  logic [NM-1:0]       m_gnt_o;
  logic [NM-1:0]       m_rvalid_o;
  logic [DW-1:0]       m_rdata_o;
  logic                m_err_o;
  logic [NS-1:0]       s_req_o;
  logic [AW-1:0]       s_addr_o;
  logic                s_we_o;
  logic [DW-1:0]       s_wdata_o;
  logic [BW-1:0]       s_be_o;
  logic [NS-1:0]       s_gnt_i;
  logic [NS-1:0]       s_rvalid_i;
  logic [NS*DW-1:0]    s_rdata_i;
  logic [NS-1:0]       s_err_i;
  logic                timeout_o;

  soc_periph_router #(
    .NrMasters(NM), .NrSlaves(NS), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int id; logic [63:0] rdata; logic err; int lat; } rsp_t;
  typedef struct { int idx; logic [63:0] addr; logic we; logic [63:0] wdata; logic [7:0] be; } sreq_t;

  rsp_t        exp_rsp[$];
  sreq_t       exp_s[$];
  int          exp_gnt[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          tmo_cnt = 0;
  int          gnt_cyc[NM];
  logic [63:0] slv_rdata[NS];
  logic [NS-1:0] slv_err;
  logic [NS-1:0] rsp_en;
  logic [NS-1:0] force_rv;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Queue one expected transaction; idx < 0 means a decode miss with no target request.
  task automatic expect_txn(input int m, input logic [63:0] addr, input logic we, input logic [63:0] wd,
                            input logic [7:0] be, input int idx, input logic [63:0] rdata,
                            input logic err, input int lat);
    sreq_t s;
    rsp_t  r;
    exp_gnt.push_back(m);
    if (idx >= 0) begin
      s.idx = idx; s.addr = addr; s.we = we; s.wdata = wd; s.be = be;
      exp_s.push_back(s);
    end
    r.id = m; r.rdata = rdata; r.err = err; r.lat = lat;
    exp_rsp.push_back(r);
  endtask

  task automatic issue(input int m, input logic [63:0] addr, input logic we, input logic [63:0] wd,
                       input logic [7:0] be);
    bit got;
    got = 1'b0;
    @(posedge clk_i); #1;
    m_addr_i[m*AW +: AW]  = addr;
    m_we_i[m]             = we;
    m_wdata_i[m*DW +: DW] = wd;
    m_be_i[m*BW +: BW]    = be;
    m_req_i[m]            = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk_i);
      if (m_gnt_o[m]) got = 1'b1;
    end
    if (!got) chk("gnt_wait", 64'(m_gnt_o[m]), 64'd1);
    @(posedge clk_i); #1;
    m_req_i[m] = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_gnt.size() != 0) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain", 64'(exp_rsp.size() + exp_gnt.size()), 64'd0);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic single(input int m, input logic [63:0] addr, input logic we, input logic [63:0] wd,
                        input logic [7:0] be, input int idx, input logic [63:0] rdata,
                        input logic err, input int lat);
    expect_txn(m, addr, we, wd, be, idx, rdata, err, lat);
    issue(m, addr, we, wd, be);
    wait_idle(200);
  endtask

  // Master-side monitor: grants, responses, latency and timeout pulses.
  initial begin
    int   g;
    rsp_t r;
    forever begin
      @(negedge clk_i);
      if (timeout_o) tmo_cnt++;
      if (m_gnt_o != '0) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(m_gnt_o), 64'd0);
        else begin
          g = exp_gnt.pop_front();
          chk("gnt", 64'(m_gnt_o), 64'(1 << g));
          gnt_cyc[g] = cyc;
        end
      end
      if (m_rvalid_o != '0) begin
        if (exp_rsp.size() == 0) chk("rvalid_unexpected", 64'(m_rvalid_o), 64'd0);
        else begin
          r = exp_rsp.pop_front();
          chk("rvalid_id", 64'(m_rvalid_o), 64'(1 << r.id));
          chk("rdata", m_rdata_o, r.rdata);
          chk("err", 64'(m_err_o), 64'(r.err));
          if (r.lat >= 0) chk("latency", 64'(cyc - gnt_cyc[r.id]), 64'(r.lat));
        end
      end
    end
  end

  // Target model: grants immediately, answers one cycle later unless its response is disabled.
  initial begin
    logic  pend;
    int    pidx;
    sreq_t e;
    pend = 1'b0; pidx = 0;
    s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0; s_err_i = '0;
    forever begin
      @(negedge clk_i);
      for (int i = 0; i < NS; i++) s_rdata_i[i*DW +: DW] = slv_rdata[i];
      s_err_i    = slv_err;
      s_rvalid_i = force_rv;
      if (pend && rsp_en[pidx]) s_rvalid_i[pidx] = 1'b1;
      pend    = 1'b0;
      s_gnt_i = s_req_o;
      if (s_req_o != '0) begin
        for (int i = 0; i < NS; i++) if (s_req_o[i]) pidx = i;
        pend = 1'b1;
        if (exp_s.size() == 0) chk("sreq_unexpected", 64'(s_req_o), 64'd0);
        else begin
          e = exp_s.pop_front();
          chk("s_req", 64'(s_req_o), 64'(1 << e.idx));
          chk("s_addr", s_addr_o, e.addr);
          chk("s_we", 64'(s_we_o), 64'(e.we));
          chk("s_wdata", s_wdata_o, e.wdata);
          chk("s_be", 64'(s_be_o), 64'(e.be));
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_wdata_i = '0; m_be_i = '0;
    force_rv = '0; rsp_en = '1; slv_err = '0;
    for (int i = 0; i < NS; i++) slv_rdata[i] = 64'h0;
    slv_rdata[0] = 64'h0123_4567_89AB_CDEF;
    slv_rdata[1] = 64'h6910_6910;
    slv_rdata[3] = 64'h33;
    slv_rdata[4] = 64'hDEAD_BEEF;
    slv_rdata[5] = 64'hA5A5;
    slv_rdata[6] = 64'hC1C1_C1C1;
    slv_rdata[7] = 64'h70;
    slv_rdata[8] = 64'h5555;
    slv_err[3]   = 1'b1;

    repeat (3) @(negedge clk_i);
    chk("rst_gnt", 64'(m_gnt_o), 64'd0);
    chk("rst_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("rst_rdata", m_rdata_o, 64'd0);
    chk("rst_err", 64'(m_err_o), 64'd0);
    chk("rst_sreq", 64'(s_req_o), 64'd0);
    chk("rst_saddr", s_addr_o, 64'd0);
    chk("rst_tmo", 64'(timeout_o), 64'd0);
    rst_ni = 1'b1;

    // Both masters hammer GPIO: grants alternate starting with M0.
    expect_txn(0, 64'h4000_0000, 1'b0, 64'h0,  8'h00, 1, 64'h6910_6910, 1'b0, 3);
    expect_txn(1, 64'h4000_0008, 1'b1, 64'h11, 8'hFF, 1, 64'h6910_6910, 1'b0, 3);
    expect_txn(0, 64'h4000_0010, 1'b0, 64'h0,  8'h00, 1, 64'h6910_6910, 1'b0, 3);
    expect_txn(1, 64'h4000_0FF8, 1'b1, 64'h22, 8'h0F, 1, 64'h6910_6910, 1'b0, 3);
    fork
      begin
        issue(0, 64'h4000_0000, 1'b0, 64'h0, 8'h00);
        issue(0, 64'h4000_0010, 1'b0, 64'h0, 8'h00);
      end
      begin
        issue(1, 64'h4000_0008, 1'b1, 64'h11, 8'hFF);
        issue(1, 64'h4000_0FF8, 1'b1, 64'h22, 8'h0F);
      end
    join
    wait_idle(200);

    single(0, 64'h1000_0004, 1'b0, 64'h0,    8'h00, 4,  64'hDEAD_BEEF, 1'b0, 3);
    single(1, 64'h6000_0000, 1'b1, 64'hABCD, 8'hFF, -1, 64'h0,         1'b1, 1);

    single(0, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 0,  64'h0123_4567_89AB_CDEF, 1'b0, 3);
    single(0, 64'hBFFF_FFFF, 1'b0, 64'h0, 8'h00, 0,  64'h0123_4567_89AB_CDEF, 1'b0, 3);
    single(0, 64'hC000_0000, 1'b0, 64'h0, 8'h00, -1, 64'h0,    1'b1, 1);
    single(0, 64'h0C3F_FFFE, 1'b0, 64'h0, 8'h00, 5,  64'hA5A5, 1'b0, 3);
    single(0, 64'h0FFF_FFFF, 1'b0, 64'h0, 8'h00, -1, 64'h0,    1'b1, 1);
    single(0, 64'h0000_0000, 1'b0, 64'h0, 8'h00, 8,  64'h5555, 1'b0, 3);
    single(0, 64'h0000_0FFF, 1'b0, 64'h0, 8'h00, 8,  64'h5555, 1'b0, 3);
    single(0, 64'h0000_1000, 1'b0, 64'h0, 8'h00, -1, 64'h0,    1'b1, 1);

    // Silent CLINT: abort with an error response, then a stray late response must be dropped.
    rsp_en[6] = 1'b0;
    single(0, 64'h0200_0000, 1'b0, 64'h0, 8'h00, 6, 64'h0, 1'b1, -1);
    chk("tmo_pulses", 64'(tmo_cnt), 64'd1);
    force_rv = 10'h040;
    repeat (2) @(negedge clk_i);
    force_rv = '0;
    repeat (3) @(negedge clk_i);
    rsp_en[6] = 1'b1;
    single(0, 64'h5000_0000, 1'b0, 64'h0, 8'h00, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 3);

    // Reset while M1 waits on a stalled DRAM response.
    rsp_en[0] = 1'b0;
    exp_gnt.push_back(1);
    begin
      sreq_t s;
      s.idx = 0; s.addr = 64'h8000_0010; s.we = 1'b1; s.wdata = 64'h5A5A; s.be = 8'hF0;
      exp_s.push_back(s);
    end
    issue(1, 64'h8000_0010, 1'b1, 64'h5A5A, 8'hF0);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_sreq", 64'(s_req_o), 64'd0);
    chk("mid_rst_saddr", s_addr_o, 64'd0);
    chk("mid_rst_swe", 64'(s_we_o), 64'd0);
    chk("mid_rst_swdata", s_wdata_o, 64'd0);
    chk("mid_rst_sbe", 64'(s_be_o), 64'd0);
    chk("mid_rst_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("mid_rst_tmo", 64'(timeout_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    rsp_en[0] = 1'b1;
    chk("mid_rst_no_rsp", 64'(exp_gnt.size() + exp_s.size()), 64'd0);

    // First request after reset goes to M0 even though M1 asks at the same time.
    expect_txn(0, 64'h0001_0000, 1'b0, 64'h0, 8'h00, 7, 64'h70, 1'b0, 3);
    expect_txn(1, 64'h207F_FFF8, 1'b0, 64'h0, 8'h00, 3, 64'h33, 1'b1, 3);
    fork
      issue(0, 64'h0001_0000, 1'b0, 64'h0, 8'h00);
      issue(1, 64'h207F_FFF8, 1'b0, 64'h0, 8'h00);
    join
    wait_idle(200);

    chk("tmo_total", 64'(tmo_cnt), 64'd1);
    chk("sreq_left", 64'(exp_s.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
